// File: rtl/double_ram_pkg.sv
// double_ram_pkg -- shared types and helpers for the double_ram_clr RAM.
//   state_e  : clear-engine FSM state (ST_CLEAR sweeps, ST_RUN serves ports)
//   depth_of : number of words addressed by an addr_w-bit address
package double_ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/double_ram_core.sv
// double_ram_core -- storage array with one write port and one registered
// read port on a single clock.
//   clk, rst_n : clock, async active-low reset (clears only the read register)
//   we/waddr/wdata : write port, word written at the rising edge
//   re/raddr       : read port; rdata loads when re=1, otherwise holds
//   rdata          : registered read data
// Macro DOUBLE_RAM_BYPASS_EN: defined -> write-first on a same-address
// read/write collision; undefined -> read-first (old word returned).
module double_ram_core
  import double_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  // Storage is never reset; the clear sweep in the top level initialises it.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] q_d, q_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
`ifdef DOUBLE_RAM_BYPASS_EN
    // Forward the incoming write word when it targets the address being read.
    rd_word = (we && (waddr == raddr)) ? wdata : mem[raddr];
`else
    rd_word = mem[raddr];
`endif
    q_d = re ? rd_word : q_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign rdata = q_q;

endmodule

// File: rtl/double_ram_clr.sv
// double_ram_clr -- parametrised simple dual-port RAM with a clear engine.
//   clock, rst_n            : single clock, async active-low reset
//   data/wraddress/wren     : write port
//   rdaddress/rden          : read port, 1-cycle latency
//   clr                     : one-cycle request to re-run the clear sweep
//   q, q_valid              : registered read data and its update flag
//   busy                    : sweep in progress, port accesses ignored
//   state_dbg               : current FSM state (0 = ST_CLEAR, 1 = ST_RUN)
// Macro DOUBLE_RAM_BYPASS_EN selects write-first collision behaviour in
// double_ram_core; read-first when undefined.
// Handshake: no back-pressure. A write or read is accepted at a rising edge
// exactly when busy=0, clr=0 and wren/rden=1; q_valid=1 marks the cycle after
// an accepted read.
module double_ram_clr
  import double_ram_pkg::*;
#(
  parameter int unsigned        DATA_W   = 4,
  parameter int unsigned        ADDR_W   = 3,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  input  logic              rden,
  input  logic              clr,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              busy,
  output logic              state_dbg
);

  localparam int unsigned       DEPTH     = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              busy_d, busy_q;
  logic              q_valid_d, q_valid_q;

  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_re;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    core_we    = 1'b0;
    core_waddr = wraddress;
    core_wdata = data;
    core_re    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        core_we    = 1'b1;
        core_waddr = cnt_q;
        core_wdata = INIT_VAL;
        cnt_d      = cnt_q + 1'b1;   // wraps to 0 after LAST_ADDR
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clr) begin
          // clr takes priority; any same-cycle access is dropped.
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
          core_we = wren;
          core_re = rden;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
    // busy is taken from the next state so it is a plain flop output.
    busy_d    = (state_d == ST_CLEAR);
    q_valid_d = core_re;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      q_valid_q <= q_valid_d;
    end
  end

  double_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clock),
    .rst_n (rst_n),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .re    (core_re),
    .raddr (rdaddress),
    .rdata (q)
  );

  assign q_valid   = q_valid_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_double_ram_clr.sv
// tb_double_ram_clr -- directed bench for double_ram_clr at default sizes
// (DATA_W=4, ADDR_W=3). Inputs change 1ns after a rising edge; outputs are
// checked at the same point, i.e. after the edge that produced them.
module tb_double_ram_clr;

  logic       clock;
  logic       rst_n;
  logic [3:0] data;
  logic [2:0] wraddress;
  logic       wren;
  logic [2:0] rdaddress;
  logic       rden;
  logic       clr;
  logic [3:0] q;
  logic       q_valid;
  logic       busy;
  logic       state_dbg;

  int n_checks;
  int n_fails;

  double_ram_clr dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .rden      (rden),
    .clr       (clr),
    .q         (q),
    .q_valid   (q_valid),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // single checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wren = 1'b0; rden = 1'b0; clr = 1'b0;
    data = '0; wraddress = '0; rdaddress = '0;
  endtask

  // Checks busy across a full sweep whose first write happens at the next edge.
  task automatic expect_sweep(input string tag);
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("%s_busy_e%0d", tag, k), busy, (k < 7) ? 1 : 0);
      check($sformatf("%s_qv_e%0d", tag, k), q_valid, 0);
    end
  endtask

  task automatic write_word(input logic [2:0] a, input logic [3:0] d);
    wren = 1'b1; wraddress = a; data = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [3:0] exp);
    rden = 1'b1; rdaddress = a;
    tick();
    check($sformatf("%s_q_a%0d", tag, a), q, exp);
    check($sformatf("%s_qv_a%0d", tag, a), q_valid, 1);
    rden = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle_inputs();
    rst_n = 1'b0;
    #23;
    check("rst_q", q, 0);
    check("rst_qv", q_valid, 0);
    check("rst_busy", busy, 1);
    check("rst_state", state_dbg, 0);

    // Release reset 1ns after an edge; the next edge is sweep edge 0.
    @(posedge clock); #1;
    rst_n = 1'b1;
    expect_sweep("init");
    check("init_state_run", state_dbg, 1);

    for (int i = 0; i < 8; i++) read_check("init_rd", 3'(i), 4'd0);

    // Fill 7-i, read back.
    for (int i = 0; i < 8; i++) write_word(3'(i), 4'(7 - i));
    for (int i = 0; i < 8; i++) read_check("fill_rd", 3'(i), 4'(7 - i));
    tick();
    check("fill_idle_qv", q_valid, 0);

    // Same-cycle same-address collision on mem[3] (holds 4).
    wren = 1'b1; wraddress = 3'd3; data = 4'd9;
    rden = 1'b1; rdaddress = 3'd3;
    tick();
    wren = 1'b0; rden = 1'b0;
`ifdef DOUBLE_RAM_BYPASS_EN
    check("coll_q", q, 9);
`else
    check("coll_q", q, 4);
`endif
    check("coll_qv", q_valid, 1);
    read_check("coll_after", 3'd3, 4'd9);

    // clr with ignored write/read traffic during the sweep. Also drop a
    // same-cycle write to address 5.
    clr = 1'b1; wren = 1'b1; wraddress = 3'd5; data = 4'd11;
    tick();
    clr = 1'b0;
    check("clr_busy_n", busy, 1);
    check("clr_qv_n", q_valid, 0);
    wren = 1'b1; wraddress = 3'd2; data = 4'd15;
    rden = 1'b1; rdaddress = 3'd6;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("clr_busy_e%0d", k), busy, (k < 8) ? 1 : 0);
      check($sformatf("clr_qhold_e%0d", k), q, 9);
      check($sformatf("clr_qv_e%0d", k), q_valid, 0);
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) read_check("clr_rd", 3'(i), 4'd0);

    // Reset while the clear counter is 5.
    write_word(3'd1, 4'd6);
    read_check("pre_rst", 3'd1, 4'd6);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 1; k <= 5; k++) tick();   // counter now 5
    check("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_q", q, 0);
    check("mid_rst_qv", q_valid, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_state", state_dbg, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    expect_sweep("rst2");

    // Hold q with rden low while rdaddress moves.
    write_word(3'd1, 4'd6);
    write_word(3'd4, 4'd3);
    read_check("hold_rd", 3'd1, 4'd6);
    for (int k = 0; k < 5; k++) begin
      rdaddress = 3'(k + 2);
      tick();
      check($sformatf("hold_q_%0d", k), q, 6);
      check($sformatf("hold_qv_%0d", k), q_valid, 0);
    end
    read_check("hold_after", 3'd4, 4'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
